// File: rtl/booth_r4_ctrl.sv
// Control sequencer for the radix-4 Booth multiplier: one multiplication per start
// pulse (init, operand load, WIDTH/2 add/shift iterations, result unload).
module booth_r4_ctrl #(
    parameter  int WIDTH = 8,
    localparam int ITER  = WIDTH / 2,
    localparam int CW    = $clog2(ITER + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    q_low,
    output logic          c0,
    output logic          c1,
    output logic          c2,
    output logic          c3,
    output logic          c4,
    output logic          c5,
    output logic          c6,
    output logic          c7,
    output logic          c8,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_LOAD_M = 4'd2;
    localparam logic [3:0] S_LOAD_Q = 4'd3;
    localparam logic [3:0] S_ADD    = 4'd4;
    localparam logic [3:0] S_SHIFT  = 4'd5;
    localparam logic [3:0] S_OUT_A  = 4'd6;
    localparam logic [3:0] S_OUT_Q  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [CW:0] ITER_L = (CW + 1)'(ITER);

    logic [3:0]    state_r;
    logic [3:0]    next_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW:0]   cnt_inc_s;

    assign cnt_inc_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
    assign cnt       = cnt_r;

    // Next-state selection for the multiplication sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_INIT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_INIT:   next_state_s = S_LOAD_M;
            S_LOAD_M: next_state_s = S_LOAD_Q;
            S_LOAD_Q: next_state_s = S_ADD;
            S_ADD:    next_state_s = S_SHIFT;
            S_SHIFT: begin
                if (cnt_inc_s < ITER_L) begin
                    next_state_s = S_ADD;
                end else begin
                    next_state_s = S_OUT_A;
                end
            end
            S_OUT_A:  next_state_s = S_OUT_Q;
            S_OUT_Q:  next_state_s = S_DONE;
            S_DONE:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Iteration counter: cleared in INIT, advanced once per SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == S_INIT) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == S_SHIFT) begin
            cnt_r <= cnt_inc_s[CW-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Strobe decode; q_low is only looked at in ADD so X elsewhere cannot leak out.
    always_comb begin
        c0   = 1'b0;
        c1   = 1'b0;
        c2   = 1'b0;
        c3   = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        c7   = 1'b0;
        c8   = 1'b0;
        done = 1'b0;
        busy = (state_r != S_IDLE);
        case (state_r)
            S_INIT:   c0 = 1'b1;
            S_LOAD_M: c2 = 1'b1;
            S_LOAD_Q: c1 = 1'b1;
            S_ADD: begin
                // {c3,c4,c6} = {write A, subtract, use 2M} for the Booth digit
                case (q_low)
                    3'b001, 3'b010: begin
                        c3 = 1'b1;
                        c4 = 1'b0;
                        c6 = 1'b0;
                    end
                    3'b011: begin
                        c3 = 1'b1;
                        c4 = 1'b0;
                        c6 = 1'b1;
                    end
                    3'b100: begin
                        c3 = 1'b1;
                        c4 = 1'b1;
                        c6 = 1'b1;
                    end
                    3'b101, 3'b110: begin
                        c3 = 1'b1;
                        c4 = 1'b1;
                        c6 = 1'b0;
                    end
                    default: begin
                        c3 = 1'b0;
                        c4 = 1'b0;
                        c6 = 1'b0;
                    end
                endcase
            end
            S_SHIFT:  c5   = 1'b1;
            S_OUT_A:  c7   = 1'b1;
            S_OUT_Q:  c8   = 1'b1;
            S_DONE:   done = 1'b1;
            default: begin
                c0 = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Self-checking bench for booth_r4_ctrl: directed and random operations compared
// cycle by cycle against a cycle-index/Booth-digit reference model.
module tb_booth_r4_ctrl;

    localparam int WIDTH = 8;
    localparam int ITER  = WIDTH / 2;
    localparam int CW    = $clog2(ITER + 1);
    localparam int LAST  = 2 * ITER + 6;
    localparam int VW    = 11 + CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    q_low;
    logic          c0, c1, c2, c3, c4, c5, c6, c7, c8, busy, done;
    logic [CW-1:0] cnt;
    logic [VW-1:0] obs;
    logic [2:0]    qv [4];

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_hold = 0;

    booth_r4_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .q_low(q_low),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
        .c7(c7), .c8(c8), .busy(busy), .done(done), .cnt(cnt)
    );

    always #5 clk = ~clk;

    assign obs = {c0, c1, c2, c3, c4, c5, c6, c7, c8, busy, done, cnt};

    // Expected outputs in cycle k after the start was sampled (k=0: idle).
    function automatic logic [VW-1:0] model(input int k, input logic [2:0] q);
        logic [8:0] c;
        int         cnt_e;
        int         d;
        c     = 9'd0;
        cnt_e = cnt_hold;
        if (k >= 2 && k <= LAST) begin
            cnt_e = (k < 5) ? 0 : (((k - 4) / 2 > ITER) ? ITER : (k - 4) / 2);
        end
        if (k == 1) c[0] = 1'b1;
        if (k == 2) c[2] = 1'b1;
        if (k == 3) c[1] = 1'b1;
        if (k >= 4 && k <= 2 * ITER + 3) begin
            if (k % 2 == 0) begin
                d    = -2 * int'(q[2]) + int'(q[1]) + int'(q[0]);
                c[3] = (d != 0);
                c[4] = (d < 0);
                c[6] = (d == 2 || d == -2);
            end else begin
                c[5] = 1'b1;
            end
        end
        if (k == 2 * ITER + 4) c[7] = 1'b1;
        if (k == 2 * ITER + 5) c[8] = 1'b1;
        return {c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], c[8],
                (k >= 1 && k <= LAST), (k == LAST), CW'(cnt_e)};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One multiplication; pokes pulses start while busy, abort_at>0 resets mid-op.
    task automatic run_op(input int id, input bit pokes, input int abort_at);
        start = 1'b1;
        q_low = 3'($urandom_range(0, 7));
        @(negedge clk);
        check($sformatf("op%0d idle0", id), model(0, q_low));
        @(posedge clk); #1;
        for (int k = 1; k <= LAST; k++) begin
            start = pokes ? (k == 5 || k == LAST) : 1'($urandom_range(0, 1));
            if (k >= 4 && k <= 2 * ITER + 2 && k % 2 == 0) begin
                q_low = qv[(k - 4) / 2];
            end else begin
                q_low = 3'bxxx;
            end
            @(negedge clk);
            check($sformatf("op%0d k=%0d", id, k), model(k, q_low));
            if (k == abort_at) begin
                #1 reset = 1'b1;
                cnt_hold = 0;
                #1 check($sformatf("op%0d abort", id), model(0, q_low));
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check($sformatf("op%0d after_abort", id), model(0, q_low));
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        cnt_hold = ITER;
        start = 1'b0;
        q_low = 3'bxxx;
        @(negedge clk);
        check($sformatf("op%0d idle_after", id), model(0, q_low));
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        q_low = 3'b000;
        repeat (2) begin
            @(posedge clk); #1;
            start = ~start;
            @(negedge clk);
            check("in_reset", model(0, q_low));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_reset", model(0, q_low));
        @(posedge clk); #1;
        @(negedge clk);
        check("still_idle", model(0, q_low));
        @(posedge clk); #1;

        qv = '{3'b000, 3'b000, 3'b000, 3'b000};
        run_op(1, 1'b0, 0);
        qv = '{3'b001, 3'b011, 3'b100, 3'b101};
        run_op(2, 1'b0, 0);
        qv = '{3'b111, 3'b010, 3'b110, 3'b111};
        run_op(3, 1'b1, 0);
        qv = '{3'b000, 3'b000, 3'b000, 3'b000};
        run_op(4, 1'b0, 7);
        run_op(5, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                qv[j] = 3'($urandom_range(0, 7));
            end
            run_op(10 + i, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_r4_ctrl.md
Name: booth_r4_ctrl

Overview:
Control sequencer for the radix-4 Booth 8-bit multiplier. It drives the datapath control strobes c0..c8 that reg_q, the A accumulator, the M register, the adder and the output bus mux act on. It consumes the Booth recoding window q[1:-1] produced by reg_q. The block runs one full multiplication per start pulse: init, operand load, WIDTH/2 add/shift iterations, then result unload.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4
ITER, WIDTH/2, number of add/shift iterations (derived; not overridden)
CW, $clog2(ITER+1), iteration counter width

Ports:
clk    input   1      clock, rising edge
reset  input   1      asynchronous, active-high reset
start  input   1      request a multiplication; sampled only in IDLE
q_low  input   3      {q[1], q[0], q[-1]} from reg_q (Booth window)
c0     output  1      init: clear A, clear q[-1]
c1     output  1      load Q from inbus (multiplier)
c2     output  1      load M from inbus (multiplicand)
c3     output  1      write adder result into A
c4     output  1      adder subtract select (A - operand)
c5     output  1      arithmetic shift right by 2 of A:Q
c6     output  1      operand select 2M (0 selects M)
c7     output  1      drive A (product high byte) on outbus
c8     output  1      drive Q (product low byte) on outbus
busy   output  1      high in every state except IDLE
done   output  1      one-cycle pulse in DONE state
cnt    output  CW     completed iterations

Behaviour:
- States: IDLE, INIT, LOAD_M, LOAD_Q, ADD, SHIFT, OUT_A, OUT_Q, DONE. Single state register, binary or one-hot.
- Reset (async, level): state = IDLE, cnt = 0. All c*, busy and done read 0 while reset is high and in the first IDLE cycle after it. Reset mid-operation aborts immediately with no residual strobe.
- Transitions:
  - IDLE to INIT when start=1; otherwise stay in IDLE.
  - INIT to LOAD_M to LOAD_Q to ADD, one cycle each.
  - ADD to SHIFT.
  - SHIFT to ADD if cnt+1 < ITER, else to OUT_A. cnt increments on the SHIFT clock edge.
  - OUT_A to OUT_Q to DONE to IDLE.
- cnt clears to 0 in INIT and holds in all other states.
- Outputs are combinational decodes of the state; no registered strobes.
  - INIT: c0=1.
  - LOAD_M: c2=1.
  - LOAD_Q: c1=1.
  - SHIFT: c5=1.
  - OUT_A: c7=1.
  - OUT_Q: c8=1.
  - DONE: done=1.
- ADD is Mealy on q_low. q_low is stable in ADD because Q changes only on c1/c5.
  - 000 or 111: c3=0, c4=0, c6=0 (no operation).
  - 001 or 010: c3=1, c4=0, c6=0 (+M).
  - 011: c3=1, c4=0, c6=1 (+2M).
  - 100: c3=1, c4=1, c6=1 (-2M).
  - 101 or 110: c3=1, c4=1, c6=0 (-M).
- In any state other than ADD, c3, c4 and c6 are 0. At most one of {c0, c1, c2, c5, c7, c8} is high in any cycle.
- Latency for WIDTH=8, with start seen in cycle 0 (IDLE):
  - INIT=1, LOAD_M=2, LOAD_Q=3.
  - ADD=4/6/8/10, SHIFT=5/7/9/11.
  - OUT_A=12, OUT_Q=13, DONE=14.
  - General: DONE at cycle 2*ITER+6.
- start while busy is ignored and does not queue. start held high through DONE begins a new operation only from the following IDLE cycle, so the minimum start-to-start interval is 2*ITER+7 cycles.
- X on q_low outside ADD must not affect any output.

Test Plan:
- Reset: assert reset at t=0 for 2 cycles, toggle start during reset -> all c*, busy, done = 0 and cnt = 0; state remains IDLE one cycle after release with start=0.
- Basic sequence: start pulse at cycle 0, q_low held 000 -> c0@1, c2@2, c1@3, c5@5/7/9/11, c3 never high, c7@12, c8@13, done@14 for exactly one cycle, busy high cycles 1-14, cnt reads 4 at cycle 12.
- Recoding: drive q_low 001, 011, 100, 101 on the four ADD cycles (4, 6, 8, 10) -> {c3,c4,c6} = 100, 101, 111, 110 respectively; 111 on any ADD cycle gives 000.
- Start while busy: pulse start at cycles 5 and 14 -> no change to sequence or cnt; next INIT occurs only after a start sampled in IDLE (cycle 15 or later).
- Mid-operation reset: assert reset at cycle 7 (SHIFT, c5 high) -> c5 drops asynchronously, busy = 0, cnt = 0; a new start then reproduces the full basic sequence timing.
